// File: rtl/matmul_sequencer.sv
// Sequences one square matrix multiply C = A x B over single-port A/B/C buffers.
// One MAC step per clock; elements are produced in row-major order.
module matmul_sequencer #(
    parameter int MAX_N  = 8,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        n,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_addr,
    output logic [ACC_W-1:0]  c_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        ACC,
        WRITE,
        DONE
    } state_t;

    localparam logic [3:0] MAX_N4 = 4'(MAX_N);

    state_t            state;
    logic [3:0]        n_l;
    logic [3:0]        i;
    logic [3:0]        j;
    logic [3:0]        k;
    logic [ADDR_W-1:0] row_base;
    logic [ACC_W-1:0]  acc;
    logic              v;

    logic [ACC_W-1:0]  acc_sum;
    logic [3:0]        last;
    logic [3:0]        j_nx;
    logic [3:0]        i_nx;
    logic [ADDR_W-1:0] n_a;
    logic [ADDR_W-1:0] row_nx;
    logic              row_end;
    logic              n_ok;

    // A/B addresses advance incrementally: a by 1 and b by n per k step.
    always_comb begin
        acc_sum = acc;
        if (v) begin
            acc_sum = acc + (ACC_W'(a_data) * ACC_W'(b_data));
        end
        last    = n_l - 4'd1;
        row_end = (j == last);
        j_nx    = row_end ? 4'd0 : j + 4'd1;
        i_nx    = row_end ? i + 4'd1 : i;
        n_a     = ADDR_W'(n_l);
        row_nx  = row_end ? row_base + n_a : row_base;
        n_ok    = (n != 4'd0) && (n <= MAX_N4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            n_l      <= '0;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            row_base <= '0;
            acc      <= '0;
            v        <= 1'b0;
            rd_en    <= 1'b0;
            a_addr   <= '0;
            b_addr   <= '0;
            c_we     <= 1'b0;
            c_addr   <= '0;
            c_data   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else if (abort && state != IDLE) begin
            state    <= IDLE;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            row_base <= '0;
            acc      <= '0;
            v        <= 1'b0;
            rd_en    <= 1'b0;
            a_addr   <= '0;
            b_addr   <= '0;
            c_we     <= 1'b0;
            c_addr   <= '0;
            c_data   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            v   <= rd_en;
            acc <= acc_sum;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (n_ok) begin
                            state    <= RUN;
                            n_l      <= n;
                            i        <= '0;
                            j        <= '0;
                            k        <= '0;
                            row_base <= '0;
                            acc      <= '0;
                            rd_en    <= 1'b1;
                            a_addr   <= '0;
                            b_addr   <= '0;
                            busy     <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (k == last) begin
                        state  <= ACC;
                        rd_en  <= 1'b0;
                        a_addr <= '0;
                        b_addr <= '0;
                    end else begin
                        k      <= k + 4'd1;
                        a_addr <= a_addr + ADDR_W'(1);
                        b_addr <= b_addr + n_a;
                    end
                end
                ACC: begin
                    state  <= WRITE;
                    c_we   <= 1'b1;
                    c_addr <= row_base + ADDR_W'(j);
                    c_data <= acc_sum;
                end
                WRITE: begin
                    c_we     <= 1'b0;
                    c_addr   <= '0;
                    c_data   <= '0;
                    acc      <= '0;
                    k        <= '0;
                    j        <= j_nx;
                    i        <= i_nx;
                    row_base <= row_nx;
                    if (row_end && i == last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state  <= RUN;
                        rd_en  <= 1'b1;
                        a_addr <= row_nx;
                        b_addr <= ADDR_W'(j_nx);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    err      <= 1'b0;
                    i        <= '0;
                    j        <= '0;
                    k        <= '0;
                    row_base <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: expected reads and writes are queued
// at job start and popped as the DUT strobes its buffers.
module tb_matmul_sequencer;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [3:0]        n = 4'd0;
    logic              rd_en;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] a_data = '0;
    logic [DATA_W-1:0] b_data = '0;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [ACC_W-1:0]  c_data;
    logic              busy;
    logic              done;
    logic              err;

    matmul_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .abort  (abort),
        .n      (n),
        .rd_en  (rd_en),
        .a_addr (a_addr),
        .b_addr (b_addr),
        .a_data (a_data),
        .b_data (b_data),
        .c_we   (c_we),
        .c_addr (c_addr),
        .c_data (c_data),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
    } pair_t;

    logic [DATA_W-1:0] a_mem [64];
    logic [DATA_W-1:0] b_mem [64];
    pair_t sb_rd[$];
    pair_t sb_wr[$];

    int n_chk  = 0;
    int n_pass = 0;
    bit mon_on = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= a_mem[a_addr];
            b_data <= b_mem[b_addr];
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            pair_t e;
            if (rd_en) begin
                if (sb_rd.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    e = sb_rd.pop_front();
                    chk("a_addr", 32'(a_addr), e.a);
                    chk("b_addr", 32'(b_addr), e.b);
                end
            end else begin
                chk("ab_addr_idle", {a_addr, b_addr}, 0);
            end
            if (c_we) begin
                if (sb_wr.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    e = sb_wr.pop_front();
                    chk("c_addr", 32'(c_addr), e.a);
                    chk("c_data", 32'(c_data), e.b);
                end
            end else begin
                chk("c_addr_idle", 32'(c_addr), 0);
            end
            chk("err_without_done", 32'(err & ~done), 0);
        end
    end

    task automatic push_expect(input int nn);
        pair_t p;
        int sum;
        for (int i = 0; i < nn; i++) begin
            for (int j = 0; j < nn; j++) begin
                sum = 0;
                for (int k = 0; k < nn; k++) begin
                    p.a = i * nn + k;
                    p.b = k * nn + j;
                    sb_rd.push_back(p);
                    sum += int'(a_mem[i*nn+k]) * int'(b_mem[k*nn+j]);
                end
                p.a = i * nn + j;
                p.b = sum;
                sb_wr.push_back(p);
            end
        end
    endtask

    task automatic run_job(input int nn, input int restart_at);
        bit valid;
        int lat;
        int busy_cnt;
        int exp_lat;
        bit got_done;
        valid   = (nn >= 1) && (nn <= 8);
        exp_lat = valid ? nn * nn * (nn + 2) + 1 : 1;
        if (valid) push_expect(nn);
        @(negedge clk);
        n = 4'(nn);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_cnt = 0;
        got_done = 1'b0;
        while (!got_done && lat <= exp_lat + 8) begin
            if (done) begin
                got_done = 1'b1;
                chk("err_flag", 32'(err), 32'(!valid));
            end else begin
                if (busy) busy_cnt++;
                if (lat == restart_at) begin
                    start = 1'b1;
                    n = 4'd3;
                end
                @(negedge clk);
                start = 1'b0;
                n = 4'(nn);
                lat++;
            end
        end
        chk("done_seen", 32'(got_done), 1);
        chk("latency", lat, exp_lat);
        chk("busy_cycles", busy_cnt, exp_lat - 1);
        chk("busy_at_done", 32'(busy), 0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
        chk("rd_left", sb_rd.size(), 0);
        chk("wr_left", sb_wr.size(), 0);
    endtask

    task automatic run_cut(input int nn, input int at, input bit use_rst);
        int dones;
        push_expect(nn);
        @(negedge clk);
        n = 4'(nn);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int lat = 1; lat < at; lat++) @(negedge clk);
        if (use_rst) rst = 1'b1;
        else abort = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        abort = 1'b0;
        sb_rd.delete();
        sb_wr.delete();
        chk("cut_rd_en", 32'(rd_en), 0);
        chk("cut_c_we", 32'(c_we), 0);
        chk("cut_busy", 32'(busy), 0);
        chk("cut_done", 32'(done), 0);
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("cut_no_done", dones, 0);
    endtask

    task automatic fill(input int nn, input int mode);
        for (int x = 0; x < 64; x++) begin
            a_mem[x] = '0;
            b_mem[x] = '0;
        end
        for (int x = 0; x < nn * nn; x++) begin
            unique case (mode)
                0: begin
                    a_mem[x] = 8'(x + 1);
                    b_mem[x] = 8'(x + 5);
                end
                1: begin
                    a_mem[x] = 8'd255;
                    b_mem[x] = 8'd255;
                end
                2: begin
                    a_mem[x] = (x / nn == x % nn) ? 8'd1 : 8'd0;
                    b_mem[x] = 8'(x + 1);
                end
                default: begin
                    a_mem[x] = 8'($urandom_range(0, 255));
                    b_mem[x] = 8'($urandom_range(0, 255));
                end
            endcase
        end
    endtask

    initial begin
        fill(2, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_c_we", 32'(c_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_c_data", 32'(c_data), 0);
        mon_on = 1'b1;

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 0);
        chk("idle_abort_done", 32'(done), 0);

        fill(2, 0);
        run_job(2, 0);
        fill(1, 1);
        run_job(1, 0);
        fill(8, 1);
        run_job(8, 0);
        fill(3, 2);
        run_job(3, 0);
        run_job(0, 0);
        run_job(9, 0);
        fill(5, 3);
        run_job(5, 0);
        fill(2, 0);
        run_job(2, 5);
        run_cut(2, 6, 1'b0);
        run_cut(2, 9, 1'b1);
        fill(2, 3);
        run_job(2, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
